// File: rtl/fizzbuzz_decoder.sv
// Purpose:      receive-side checker for the FizzBuzz flag stream; acquires the generator phase and rebuilds its counter.
// Latency:      every output is registered and reflects the sample accepted on the previous posedge (1 cycle).
// Backpressure: none; in_valid qualifies samples and cycles without it leave all state untouched.
//
// Ports:
//   clk, reset                  sole clock; synchronous active-high reset
//   in_valid                    qualifies the fizz/buzz/fizzbuzz flag sample of this cycle
//   fizz, buzz, fizzbuzz        received flags
//   locked                      phase acquired and verified
//   count / count_valid         reconstructed counter value of the last reported sample / one-cycle report pulse
//   error                       one-cycle pulse on a mismatch while locked
//   illegal                     one-cycle pulse on a sample with fizzbuzz != (fizz & buzz)
//   err_count                   saturating count of error pulses
module fizzbuzz_decoder #(
   parameter int FIZZ       = 3,
   parameter int BUZZ       = 5,
   parameter int MAX_CYCLES = 100,
   parameter int ERR_W      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic                          fizz,
   input  logic                          buzz,
   input  logic                          fizzbuzz,
   output logic                          locked,
   output logic [$clog2(MAX_CYCLES)-1:0] count,
   output logic                          count_valid,
   output logic                          error,
   output logic                          illegal,
   output logic [ERR_W-1:0]              err_count
);

   localparam int CW = $clog2(MAX_CYCLES);
   localparam int MW = $clog2(MAX_CYCLES + 1);
   // A divisor of 1 needs no phase state, but keep a 1-bit register so widths stay legal.
   localparam int FW = (FIZZ > 1) ? $clog2(FIZZ) : 1;
   localparam int BW = (BUZZ > 1) ? $clog2(BUZZ) : 1;

   localparam logic [CW-1:0]    EXP_LAST   = CW'(MAX_CYCLES - 1);
   localparam logic [CW-1:0]    EXP_ONE    = CW'(1);
   localparam logic [MW-1:0]    MATCH_FULL = MW'(MAX_CYCLES);
   localparam logic [FW-1:0]    F_LAST     = FW'(FIZZ - 1);
   localparam logic [BW-1:0]    B_LAST     = BW'(BUZZ - 1);
   // Phase of value 1 modulo each divisor (0 when the divisor is 1).
   localparam logic [FW-1:0]    F_ONE      = (FIZZ == 1) ? FW'(0) : FW'(1);
   localparam logic [BW-1:0]    B_ONE      = (BUZZ == 1) ? BW'(0) : BW'(1);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_TRACK  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    exp_q, exp_d;
   // exp modulo FIZZ and modulo BUZZ, kept as running counters so no divider is needed.
   logic [FW-1:0]    fph_q, fph_d;
   logic [BW-1:0]    bph_q, bph_d;
   logic [MW-1:0]    match_q, match_d, match_inc;

   logic [CW-1:0]    count_d;
   logic             count_valid_d;
   logic             error_d;
   logic             illegal_d;
   logic [ERR_W-1:0] err_count_d;

   logic             pred_fizz, pred_buzz, hit, anchor, malformed;
   logic             do_adv, do_restart;

   // Prediction for exp, compared against the received flags.
   assign pred_fizz = (fph_q == '0);
   assign pred_buzz = (bph_q == '0);
   assign hit       = (fizz == pred_fizz) && (buzz == pred_buzz) &&
                      (fizzbuzz == (pred_fizz & pred_buzz));
   assign anchor    = fizz & buzz & fizzbuzz;
   assign malformed = fizzbuzz != (fizz & buzz);

   always_comb begin
      state_d       = state_q;
      exp_d         = exp_q;
      fph_d         = fph_q;
      bph_d         = bph_q;
      match_d       = match_q;
      count_d       = count;
      count_valid_d = 1'b0;
      error_d       = 1'b0;
      illegal_d     = 1'b0;
      err_count_d   = err_count;
      do_adv        = 1'b0;
      do_restart    = 1'b0;
      match_inc     = match_q + MW'(1);

      if (in_valid) begin
         illegal_d = malformed;
         case (state_q)
            S_HUNT: begin
               if (anchor) begin
                  state_d    = S_TRACK;
                  do_restart = 1'b1;
               end
            end
            S_TRACK: begin
               if (hit) begin
                  do_adv  = 1'b1;
                  match_d = match_inc;
                  // The MAX_CYCLES-th match is the re-check of value 0 after a full wrap.
                  if (match_inc == MATCH_FULL) begin
                     state_d       = S_LOCKED;
                     count_valid_d = 1'b1;
                     count_d       = exp_q;
                  end
               end else if (anchor) begin
                  do_restart = 1'b1;
               end else begin
                  state_d = S_HUNT;
               end
            end
            S_LOCKED: begin
               if (hit) begin
                  do_adv        = 1'b1;
                  count_valid_d = 1'b1;
                  count_d       = exp_q;
               end else begin
                  error_d = 1'b1;
                  if (err_count != ERR_MAX) begin
                     err_count_d = err_count + ERR_W'(1);
                  end
                  if (anchor) begin
                     state_d    = S_TRACK;
                     do_restart = 1'b1;
                  end else begin
                     state_d = S_HUNT;
                  end
               end
            end
            default: begin
               state_d = S_HUNT;
            end
         endcase
      end

      if (do_restart) begin
         // An anchor is value 0, so the next expected value is 1.
         exp_d   = EXP_ONE;
         fph_d   = F_ONE;
         bph_d   = B_ONE;
         match_d = '0;
      end else if (do_adv) begin
         if (exp_q == EXP_LAST) begin
            // MAX_CYCLES need not be a multiple of either divisor: re-zero the phases on wrap.
            exp_d = '0;
            fph_d = '0;
            bph_d = '0;
         end else begin
            exp_d = exp_q + CW'(1);
            fph_d = (fph_q == F_LAST) ? '0 : fph_q + FW'(1);
            bph_d = (bph_q == B_LAST) ? '0 : bph_q + BW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_HUNT;
         exp_q       <= '0;
         fph_q       <= '0;
         bph_q       <= '0;
         match_q     <= '0;
         locked      <= 1'b0;
         count       <= '0;
         count_valid <= 1'b0;
         error       <= 1'b0;
         illegal     <= 1'b0;
         err_count   <= '0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         fph_q       <= fph_d;
         bph_q       <= bph_d;
         match_q     <= match_d;
         locked      <= (state_d == S_LOCKED);
         count       <= count_d;
         count_valid <= count_valid_d;
         error       <= error_d;
         illegal     <= illegal_d;
         err_count   <= err_count_d;
      end
   end

endmodule

// File: tb/tb_fizzbuzz_decoder.sv
// Purpose:      self-checking bench for fizzbuzz_decoder; two instances (ERR_W=8 and ERR_W=2) share one stimulus stream.
// Latency:      expectations are formed at each posedge and compared on the following negedge.
// Backpressure: none; stimulus inserts random in_valid=0 stalls.
module tb_fizzbuzz_decoder;

   localparam int P_FIZZ = 3;
   localparam int P_BUZZ = 5;
   localparam int P_MAX  = 100;
   localparam int CW     = $clog2(P_MAX);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          fizz = 1'b0;
   logic          buzz = 1'b0;
   logic          fizzbuzz = 1'b0;

   logic          locked_a, cv_a, err_a, ill_a;
   logic [CW-1:0] count_a;
   logic [7:0]    ec_a;
   logic          locked_b, cv_b, err_b, ill_b;
   logic [CW-1:0] count_b;
   logic [1:0]    ec_b;

   always #5 clk = ~clk;

   fizzbuzz_decoder #(.FIZZ(P_FIZZ), .BUZZ(P_BUZZ), .MAX_CYCLES(P_MAX), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
      .locked(locked_a), .count(count_a), .count_valid(cv_a), .error(err_a), .illegal(ill_a),
      .err_count(ec_a));

   fizzbuzz_decoder #(.FIZZ(P_FIZZ), .BUZZ(P_BUZZ), .MAX_CYCLES(P_MAX), .ERR_W(2)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
      .locked(locked_b), .count(count_b), .count_valid(cv_b), .error(err_b), .illegal(ill_b),
      .err_count(ec_b));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, want);
   endtask

   // ---------------- behavioural reference model ----------------
   // mode: 0 = hunting, 1 = tracking, 2 = locked
   int m_mode = 0, m_exp = 0, m_match = 0;
   int e_locked = 0, e_count = 0, e_cv = 0, e_err = 0, e_ill = 0, e_ec8 = 0, e_ec2 = 0;
   bit chk_en = 0;
   bit m_pf, m_pb, m_hit, m_anc;

   always @(posedge clk) begin
      e_cv  = 0;
      e_err = 0;
      e_ill = 0;
      if (reset) begin
         m_mode = 0; m_exp = 0; m_match = 0;
         e_locked = 0; e_count = 0; e_ec8 = 0; e_ec2 = 0;
         chk_en = 1;
      end else if (in_valid) begin
         m_pf  = (m_exp % P_FIZZ) == 0;
         m_pb  = (m_exp % P_BUZZ) == 0;
         m_hit = (fizz == m_pf) && (buzz == m_pb) && (fizzbuzz == (m_pf && m_pb));
         m_anc = fizz && buzz && fizzbuzz;
         e_ill = (fizzbuzz != (fizz && buzz)) ? 1 : 0;
         if (m_mode == 0) begin
            if (m_anc) begin m_mode = 1; m_exp = 1; m_match = 0; end
         end else if (m_hit) begin
            if (m_mode == 1) begin
               m_match++;
               if (m_match == P_MAX) begin
                  m_mode = 2; e_cv = 1; e_count = m_exp;
               end
            end else begin
               e_cv = 1; e_count = m_exp;
            end
            m_exp = (m_exp + 1) % P_MAX;
         end else begin
            if (m_mode == 2) begin
               e_err = 1;
               e_ec8 = (e_ec8 < 255) ? e_ec8 + 1 : 255;
               e_ec2 = (e_ec2 < 3) ? e_ec2 + 1 : 3;
            end
            if (m_anc) begin m_mode = 1; m_exp = 1; m_match = 0; end
            else m_mode = 0;
         end
         e_locked = (m_mode == 2) ? 1 : 0;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("locked",      locked_a, e_locked);
         check("count",       count_a,  e_count);
         check("count_valid", cv_a,     e_cv);
         check("error",       err_a,    e_err);
         check("illegal",     ill_a,    e_ill);
         check("err_count",   ec_a,     e_ec8);
         check("s.locked",    locked_b, e_locked);
         check("s.count",     count_b,  e_count);
         check("s.error",     err_b,    e_err);
         check("s.err_count", ec_b,     e_ec2);
      end
   end

   // ---------------- stimulus ----------------
   int g = 0;          // generator counter value of the next sample
   int stall_pct = 0;

   task automatic put(input logic v, input logic f, input logic b, input logic fb);
      @(negedge clk);
      in_valid = v; fizz = f; buzz = b; fizzbuzz = fb;
   endtask

   task automatic idle();
      put(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic gen_step();
      if (int'($urandom_range(99)) < stall_pct) idle();
      put(1'b1, (g % P_FIZZ) == 0, (g % P_BUZZ) == 0, (g % (P_FIZZ * P_BUZZ)) == 0);
      g = (g + 1) % P_MAX;
   endtask

   task automatic gen_fault(input int kind);
      logic f, b, fb;
      f  = (g % P_FIZZ) == 0;
      b  = (g % P_BUZZ) == 0;
      fb = f & b;
      case (kind)
         0:       f  = ~f;
         1:       b  = ~b;
         default: fb = ~fb;
      endcase
      put(1'b1, f, b, fb);
      g = (g + 1) % P_MAX;
   endtask

   task automatic step_to(input int target);
      int n = 0;
      while (g != target && n < 2 * P_MAX) begin gen_step(); n++; end
   endtask

   task automatic until_locked(input int bound);
      int n = 0;
      while (locked_a !== 1'b1 && n < bound) begin gen_step(); n++; end
      check("lock_wait", locked_a, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: clean lock from counter 0, no stalls
      do_reset();
      check("rst.locked", locked_a, 0);
      check("rst.err_count", ec_a, 0);
      stall_pct = 0; g = 0;
      repeat (P_MAX) gen_step();
      idle();
      check("clean.pre_lock", locked_a, 0);
      gen_step();
      idle();
      check("clean.locked", locked_a, 1);
      check("clean.count_valid", cv_a, 1);
      check("clean.count", count_a, 0);
      repeat (120) gen_step();

      // 4: same stream with ~30% stalls; lock still after 101 valid samples
      do_reset();
      stall_pct = 30; g = 0;
      repeat (P_MAX) gen_step();
      idle();
      check("stall.pre_lock", locked_a, 0);
      gen_step();
      idle();
      check("stall.locked", locked_a, 1);
      check("stall.count", count_a, 0);
      repeat (150) gen_step();

      // 2: mid-stream entry at counter 15 (false anchor), restart at true 0
      do_reset();
      stall_pct = 0; g = 15;
      repeat (85) gen_step();
      repeat (P_MAX) gen_step();
      idle();
      check("mid.pre_lock", locked_a, 0);
      gen_step();
      idle();
      check("mid.locked", locked_a, 1);
      check("mid.err_count", ec_a, 0);

      // 3: flip fizz at counter 7 while locked
      step_to(7);
      gen_fault(0);
      idle();
      check("fault.error", err_a, 1);
      check("fault.err_count", ec_a, 1);
      check("fault.locked", locked_a, 0);
      stall_pct = 20;
      until_locked(400);

      // 5: malformed sample while locked
      step_to(int'($urandom_range(P_MAX - 1)));
      put(1'b1, 1'b0, 1'b1, 1'b1);
      g = (g + 1) % P_MAX;
      idle();
      check("malformed.illegal", ill_a, 1);
      check("malformed.error", err_a, 1);
      until_locked(400);

      // 6: three more random faults; ERR_W=2 instance saturates at 3 yet still pulses
      for (int k = 0; k < 3; k++) begin
         step_to(int'($urandom_range(P_MAX - 1)));
         gen_fault(int'($urandom_range(2)));
         idle();
         check("sat.error", err_b, 1);
         until_locked(400);
      end
      check("sat.err_count2", ec_b, 3);
      check("sat.err_count8", ec_a, 5);

      // reset mid-TRACK: knock out of lock, re-anchor, then reset while a sample is offered
      gen_fault(1);
      step_to(0);
      repeat (31) gen_step();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b1; fizz = 1'b1; buzz = 1'b1; fizzbuzz = 1'b1;
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      check("rst2.locked", locked_a, 0);
      check("rst2.count", count_a, 0);
      check("rst2.count_valid", cv_a, 0);
      check("rst2.error", err_a, 0);
      check("rst2.illegal", ill_a, 0);
      check("rst2.err_count", ec_a, 0);

      // generator held in reset (anchors every cycle), then released
      repeat (6) put(1'b1, 1'b1, 1'b1, 1'b1);
      g = 1;
      until_locked(400);

      // random mix: anchors, garbage flags, stalls and clean samples
      for (int i = 0; i < 300; i++) begin
         int r;
         logic [2:0] rf;
         r  = int'($urandom_range(99));
         rf = 3'($urandom_range(7));
         if (r < 8)       put(1'b1, 1'b1, 1'b1, 1'b1);
         else if (r < 18) put(1'b1, rf[0], rf[1], rf[2]);
         else if (r < 30) idle();
         else             gen_step();
      end
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fizzbuzz_decoder.md
# fizzbuzz_decoder

- Receive side of the FizzBuzz generator stream.
- Consumes the per-sample `fizz`/`buzz`/`fizzbuzz` flags and aligns to the generator's counter phase.
- Reconstructs the counter value and flags every sample that deviates from the FIZZ/BUZZ/MAX_CYCLES sequence.
- Sits downstream of the generator as its checker and monitor, with an optional sample qualifier for stalled links.

## Interface

Parameters:
- `FIZZ`, 3, fizz divisor (≥1)
- `BUZZ`, 5, buzz divisor (≥1)
- `MAX_CYCLES`, 100, generator sequence length, 0..MAX_CYCLES-1 (≥2)
- `ERR_W`, 8, error counter width

Ports:
- `clk`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  qualifies the current flag sample; only valid samples advance the decoder
- `fizz`  in  1  received fizz flag
- `buzz`  in  1  received buzz flag
- `fizzbuzz`  in  1  received fizzbuzz flag
- `locked`  out  1  phase acquired and verified
- `count`  out  $clog2(MAX_CYCLES)  reconstructed counter value of the last reported sample
- `count_valid`  out  1  one-cycle pulse; `count` is meaningful
- `error`  out  1  one-cycle pulse; mismatch while LOCKED
- `illegal`  out  1  one-cycle pulse; valid sample with `fizzbuzz != (fizz & buzz)`
- `err_count`  out  ERR_W  saturating count of `error` pulses

## Operation

Definitions:
- Sample = a cycle with `in_valid`=1.
- Anchor = a sample with fizz=buzz=fizzbuzz=1.
- Prediction for value `e`: fizz=(e%FIZZ==0), buzz=(e%BUZZ==0), fizzbuzz=fizz&buzz.
- Internal registers:
  - `exp` (width of `count`): next expected value.
  - `match` ($clog2(MAX_CYCLES+1) bits): matched samples since the anchor.

States: HUNT, TRACK, LOCKED. Reset → HUNT.

- **HUNT**
  - Anchor → TRACK, exp=1, match=0.
  - Other samples are discarded; no `error`.
- **TRACK**
  - Sample equal to prediction(exp) → exp=(exp==MAX_CYCLES-1)?0:exp+1, match+1.
  - When match reaches MAX_CYCLES (the sample re-checking value 0 after wrap) → LOCKED, exp=1.
  - Mismatch that is itself an anchor → restart TRACK: exp=1, match=0.
  - Any other mismatch → HUNT.
  - No `error` pulses in TRACK.
- **LOCKED**
  - Sample equal to prediction(exp) → advance exp with wrap.
  - Mismatch → `error` pulse, `err_count`+1 (holds at 2^ERR_W-1), `locked` drops.
    - Next state is TRACK-restart if the sample is an anchor, else HUNT.
- **`illegal`**
  - Asserted in any state for a malformed sample.
  - A malformed sample can never equal a prediction, so it is a mismatch in TRACK/LOCKED.
- **`count_valid`/`count`**
  - Pulsed for the lock-completing sample (count=0) and for every matched sample in LOCKED.
  - `count` holds the last reported value between pulses.
- **Stalls**: `in_valid`=0 cycles change no state.

Aliasing:
- If MAX_CYCLES is a multiple of lcm(FIZZ,BUZZ), every anchor phase is indistinguishable.
- In that case `count` is exact only modulo lcm(FIZZ,BUZZ).
- This is accepted behaviour and is not flagged.

## Timing

- All outputs are registered and reflect the sample accepted on the previous posedge (1-cycle latency).
- Reset values:
  - `locked`=0, `count`=0, `count_valid`=0, `error`=0, `illegal`=0, `err_count`=0.
  - State HUNT, exp=0, match=0.
- Reset has priority over `in_valid` and takes effect mid-TRACK or mid-LOCKED with no error pulse.
- Lock latency from a correct anchor is the anchor plus MAX_CYCLES samples. `locked` rises one cycle after the last of those samples.
- `locked` falls one cycle after the mismatching sample, in the same cycle as `error`.
- Generator reset (all flags 1 every cycle) → repeated anchor restarts in TRACK; no errors unless LOCKED.
- `err_count` at saturation: `error` still pulses, count holds.

## Test plan

1. **Clean lock.** Reset, then generator stream from 0 with `in_valid`=1 continuously.
   - Anchor at sample 0.
   - `locked`=1 one cycle after sample index 100, with count_valid and count=0.
   - Thereafter count runs 1,2,…,99,0 with no error.
2. **Mid-stream entry.** Stream starts at counter 15.
   - False anchor at 15.
   - Mismatch at true 0 (predicted 85) restarts TRACK.
   - `locked` after 100 further samples; `error`=0 throughout.
3. **Injected fault.** While LOCKED, flip `fizz` at counter 7.
   - `error` pulse, err_count=1, `locked`=0, state HUNT.
   - Re-lock follows as in scenario 2.
4. **Stalls.** Random `in_valid`=0 gaps (~30%) on the clean stream.
   - Lock occurs after the same 101 valid samples.
   - count_valid sequence contiguous; no errors.
5. **Malformed sample.** Sample fizz=0, buzz=1, fizzbuzz=1 while LOCKED → `illegal` and `error` pulse together, state HUNT.
6. **Reset and saturation.**
   - With ERR_W=2, inject 5 faults while LOCKED → err_count saturates at 3 and the 5th fault still pulses `error`.
   - Assert `reset` mid-TRACK → all outputs return to reset values next cycle.
